// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory responder and its ROM.
package memory_responder_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;
  localparam int MAX_WAIT   = 7;
  localparam int WCNT_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD_DRIVE,
    ST_WR_DONE
  } ram_state_e;

endpackage

// File: rtl/memory_responder_sync_rom_64x16.sv
// Instruction ROM with a program-load port and a registered fetch output.
// Latency: 1 cycle from the fetch edge to data_from_rom.
// Backpressure: none; a fetch is taken on every enabled edge.
module sync_rom_64x16
  import memory_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_to_rom,
  input  logic              enable_to_rom,
  output logic [DATA_W-1:0] data_from_rom,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  logic [DATA_W-1:0] rom [2**ADDR_W];

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk_main) begin
    if (load_en) begin
      rom[load_addr] <= load_data;
    end
  end

  // A same-edge load is not yet visible here, so the old word is returned.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      data_from_rom <= '0;
    end else if (enable_to_rom) begin
      data_from_rom <= rom[address_to_rom];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: instruction ROM plus a wait-stated data RAM on a shared bus.
// Latency: ROM 1 cycle; RAM WAIT_STATES+1 cycles from acceptance to mem_ready.
// Backpressure: one RAM access in flight; requests are only sampled in IDLE.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_to_rom,
  input  logic              enable_to_rom,
  output logic [DATA_W-1:0] data_from_rom,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] address_to_ram,
  input  logic              write_enable_to_ram,
  input  logic              read_enable_to_ram,
  inout  wire  [DATA_W-1:0] data_ram,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam logic [WCNT_W-1:0] WAIT_LAST =
    WCNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  sync_rom_64x16 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk_main       (clk_main),
    .reset          (reset),
    .address_to_rom (address_to_rom),
    .enable_to_rom  (enable_to_rom),
    .data_from_rom  (data_from_rom),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data)
  );

  logic [DATA_W-1:0] ram [2**ADDR_W];

  ram_state_e        state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic              op_wr;
  logic              accept_wr, accept_rd, req_clash;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              bus_oe;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    accept_wr    = 1'b0;
    accept_rd    = 1'b0;
    req_clash    = 1'b0;
    case (state)
      ST_IDLE: begin
        wait_cnt_nxt = '0;
        if (write_enable_to_ram && read_enable_to_ram) begin
          req_clash = 1'b1;
        end else if (write_enable_to_ram) begin
          accept_wr = 1'b1;
          state_nxt = (WAIT_STATES == 0) ? ST_WR_DONE : ST_WAIT;
        end else if (read_enable_to_ram) begin
          accept_rd = 1'b1;
          state_nxt = (WAIT_STATES == 0) ? ST_RD_DRIVE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = op_wr ? ST_WR_DONE : ST_RD_DRIVE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ST_RD_DRIVE: state_nxt = ST_IDLE;
      ST_WR_DONE:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_addr  <= '0;
      op_wr    <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= req_clash;
      if (accept_wr) begin
        wr_addr <= address_to_ram;
        wr_data <= data_ram;
        op_wr   <= 1'b1;
      end
      if (accept_rd) begin
        rd_addr <= address_to_ram;
        op_wr   <= 1'b0;
      end
    end
  end

  // With zero wait states the entry edge is the acceptance edge, so the
  // write takes the live address/bus instead of the not-yet-latched copy.
  assign ram_we    = reset && (state_nxt == ST_WR_DONE);
  assign ram_waddr = (state == ST_IDLE) ? address_to_ram : wr_addr;
  assign ram_wdata = (state == ST_IDLE) ? data_ram : wr_data;

  always_ff @(posedge clk_main) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  // Driven only from the state register, so reset releases the bus at once.
  assign bus_oe    = (state == ST_RD_DRIVE);
  assign data_ram  = bus_oe ? ram[rd_addr] : {DATA_W{1'bz}};
  assign mem_ready = (state == ST_RD_DRIVE) || (state == ST_WR_DONE);

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: three responders with 1, 0 and 3 wait states.
module tb_memory_responder;

  logic        clk_main = 1'b0;
  logic        reset    = 1'b0;
  logic [5:0]  rom_addr = '0;
  logic        rom_en   = 1'b0;
  logic        load_en  = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [15:0] load_data = '0;

  logic [15:0] rom_q   [3];
  logic [5:0]  ram_addr[3];
  logic        ram_we  [3];
  logic        ram_re  [3];
  logic [15:0] tb_drv  [3];
  logic        tb_oe   [3];
  logic        rdy     [3];
  logic        err     [3];
  logic        oe_obs  [3];
  wire  [15:0] bus0, bus1, bus2;

  int checks   = 0;
  int failures = 0;

  always #5 clk_main = ~clk_main;

  assign bus0 = tb_oe[0] ? tb_drv[0] : 16'hzzzz;
  assign bus1 = tb_oe[1] ? tb_drv[1] : 16'hzzzz;
  assign bus2 = tb_oe[2] ? tb_drv[2] : 16'hzzzz;

  memory_responder #(.ADDR_W(6), .DATA_W(16), .WAIT_STATES(1)) u_dut0 (
    .clk_main(clk_main), .reset(reset),
    .address_to_rom(rom_addr), .enable_to_rom(rom_en), .data_from_rom(rom_q[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .address_to_ram(ram_addr[0]), .write_enable_to_ram(ram_we[0]),
    .read_enable_to_ram(ram_re[0]), .data_ram(bus0),
    .mem_ready(rdy[0]), .mem_err(err[0]));

  memory_responder #(.ADDR_W(6), .DATA_W(16), .WAIT_STATES(0)) u_dut1 (
    .clk_main(clk_main), .reset(reset),
    .address_to_rom(rom_addr), .enable_to_rom(rom_en), .data_from_rom(rom_q[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .address_to_ram(ram_addr[1]), .write_enable_to_ram(ram_we[1]),
    .read_enable_to_ram(ram_re[1]), .data_ram(bus1),
    .mem_ready(rdy[1]), .mem_err(err[1]));

  memory_responder #(.ADDR_W(6), .DATA_W(16), .WAIT_STATES(3)) u_dut2 (
    .clk_main(clk_main), .reset(reset),
    .address_to_rom(rom_addr), .enable_to_rom(rom_en), .data_from_rom(rom_q[2]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .address_to_ram(ram_addr[2]), .write_enable_to_ram(ram_we[2]),
    .read_enable_to_ram(ram_re[2]), .data_ram(bus2),
    .mem_ready(rdy[2]), .mem_err(err[2]));

  // Bus drive is observed at the tristate enable, since undriven nets read as 0 here.
  assign oe_obs[0] = u_dut0.bus_oe;
  assign oe_obs[1] = u_dut1.bus_oe;
  assign oe_obs[2] = u_dut2.bus_oe;

  function automatic logic [15:0] bus_val(input int i);
    case (i)
      0:       return bus0;
      1:       return bus1;
      default: return bus2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  // Issue one RAM access and check ready/bus on every cycle up to completion and one after.
  task automatic access(input int i, input bit is_wr, input logic [5:0] a,
                        input logic [15:0] d, input int lat);
    ram_addr[i] = a;
    if (is_wr) begin
      ram_we[i] = 1'b1;
      tb_drv[i] = d;
      tb_oe[i]  = 1'b1;
    end else begin
      ram_re[i] = 1'b1;
    end
    tick();
    ram_we[i] = 1'b0;
    ram_re[i] = 1'b0;
    tb_oe[i]  = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      check($sformatf("rdy_u%0d_a%0d_k%0d", i, a, k), 32'(rdy[i]), 32'(k == lat));
      check($sformatf("oe_u%0d_a%0d_k%0d", i, a, k), 32'(oe_obs[i]), 32'(!is_wr && k == lat));
      if (!is_wr && k == lat)
        check($sformatf("rdat_u%0d_a%0d", i, a), 32'(bus_val(i)), 32'(d));
      if (k < lat) tick();
    end
    tick();
    check($sformatf("rdy_after_u%0d_a%0d", i, a), 32'(rdy[i]), 32'd0);
    check($sformatf("oe_after_u%0d_a%0d", i, a), 32'(oe_obs[i]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      ram_addr[i] = '0; ram_we[i] = 1'b0; ram_re[i] = 1'b0;
      tb_drv[i] = '0; tb_oe[i] = 1'b0;
    end

    // Reset state
    #3;
    check("rst_rom_q", 32'(rom_q[0]), 32'd0);
    check("rst_rdy", 32'(rdy[0]), 32'd0);
    check("rst_err", 32'(err[0]), 32'd0);
    check("rst_oe", 32'(oe_obs[0]), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // ROM load then fetch
    load_en = 1'b1; load_addr = 6'd5; load_data = 16'h1234;
    tick();
    load_addr = 6'd6; load_data = 16'hBEEF;
    tick();
    load_en = 1'b0;
    rom_en = 1'b1; rom_addr = 6'd5;
    tick();
    check("rom_fetch5", 32'(rom_q[0]), 32'h1234);
    rom_addr = 6'd6;
    tick();
    check("rom_fetch6", 32'(rom_q[0]), 32'hBEEF);
    rom_en = 1'b0; rom_addr = 6'd5;
    tick();
    check("rom_hold1", 32'(rom_q[0]), 32'hBEEF);
    tick();
    check("rom_hold2", 32'(rom_q[0]), 32'hBEEF);

    // Same-edge load and fetch returns the old word
    load_en = 1'b1; load_addr = 6'd2; load_data = 16'h1111;
    tick();
    load_data = 16'h2222; rom_en = 1'b1; rom_addr = 6'd2;
    tick();
    check("rom_collide_old", 32'(rom_q[0]), 32'h1111);
    load_en = 1'b0;
    tick();
    check("rom_collide_new", 32'(rom_q[0]), 32'h2222);
    check("rom_collide_new_u1", 32'(rom_q[1]), 32'h2222);
    check("rom_collide_new_u2", 32'(rom_q[2]), 32'h2222);
    rom_en = 1'b0;

    // One wait state: write then read back
    access(0, 1'b1, 6'd12, 16'hA5A5, 2);
    access(0, 1'b0, 6'd12, 16'hA5A5, 2);

    // Zero wait states, including the top address
    access(1, 1'b1, 6'd63, 16'h0F0F, 1);
    access(1, 1'b0, 6'd63, 16'h0F0F, 1);

    // Read held high: a completion every second cycle
    ram_addr[1] = 6'd63; ram_re[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("b2b_rdy_k%0d", k), 32'(rdy[1]), 32'(k % 2));
      if (k % 2 == 1) check($sformatf("b2b_dat_k%0d", k), 32'(bus1), 32'h0F0F);
    end
    ram_re[1] = 1'b0;
    tick();
    check("b2b_rdy_end", 32'(rdy[1]), 32'd0);

    // Read/write clash: error pulse only, RAM untouched, bus idle
    access(0, 1'b1, 6'd3, 16'h3333, 2);
    ram_addr[0] = 6'd3; ram_we[0] = 1'b1; ram_re[0] = 1'b1;
    tb_drv[0] = 16'hDEAD; tb_oe[0] = 1'b1;
    tick();
    ram_we[0] = 1'b0; ram_re[0] = 1'b0; tb_oe[0] = 1'b0;
    check("clash_err", 32'(err[0]), 32'd1);
    check("clash_rdy", 32'(rdy[0]), 32'd0);
    check("clash_oe", 32'(oe_obs[0]), 32'd0);
    tick();
    check("clash_err_end", 32'(err[0]), 32'd0);
    check("clash_rdy_end", 32'(rdy[0]), 32'd0);
    check("clash_oe_end", 32'(oe_obs[0]), 32'd0);
    access(0, 1'b0, 6'd3, 16'h3333, 2);

    // Three wait states: reset during WAIT aborts the write
    access(2, 1'b1, 6'd9, 16'h5555, 4);
    ram_addr[2] = 6'd9; ram_we[2] = 1'b1; tb_drv[2] = 16'h7777; tb_oe[2] = 1'b1;
    tick();
    ram_we[2] = 1'b0; tb_oe[2] = 1'b0;
    tick();
    check("abort_rdy_wait", 32'(rdy[2]), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("abort_oe", 32'(oe_obs[2]), 32'd0);
    check("abort_rdy", 32'(rdy[2]), 32'd0);
    check("abort_rom_q", 32'(rom_q[2]), 32'd0);
    tick();
    tick();
    tick();
    check("abort_oe_held", 32'(oe_obs[2]), 32'd0);
    reset = 1'b1;
    tick();
    access(2, 1'b0, 6'd9, 16'h5555, 4);

    // ROM contents survive reset
    rom_en = 1'b1; rom_addr = 6'd5;
    tick();
    check("rom_retained", 32'(rom_q[0]), 32'h1234);
    rom_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
